div_seq_param: RTL and testbench

//  Parametrised multi-cycle restoring divider, signed or unsigned per operation, one quotient bit/cycle.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_restore_step.sv | 24 ++
 rtl/div_seq_param.sv | 159 +++++++++++++++
 tb/tb_div_seq_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding plus conditional two's-complement negate / magnitude helpers.
package div_pkg;

  localparam int STATE_W = 2;

  // Widest operand the helper functions handle; callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int MAX_W = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negate when neg is set; the low bits of the result are
  // correct for any narrower width.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

  // Magnitude of a value whose sign is supplied separately (unsigned mode
  // passes is_neg=0). The most negative value maps to 2^(W-1), which still
  // fits as an unsigned W-bit number.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                               input logic is_neg);
    return cond_negate(v, is_neg);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module div_restore_step
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic         q_msb,
  input  logic [W-1:0] dmag,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;

  // Compare the W+1 bit shifted remainder so a carry-out is never lost.
  always_comb begin
    shifted  = {rem, q_msb};
    q_bit    = (shifted >= {1'b0, dmag});
    rem_next = q_bit ? W'(shifted - {1'b0, dmag}) : shifted[W-1:0];
  end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, signed or unsigned per operation, one
// quotient bit per cycle, valid/ready on both sides.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and
// |D| < |d| finish straight from IDLE instead of iterating.
module div_seq_param
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         signed_mode,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     rem_reg, quo_reg, dmag_reg;
  logic             q_neg_reg, r_neg_reg, dz_reg, ovf_reg;
  logic [W-1:0]     quotient_reg, remainder_reg;
  logic             dz_out_reg, ovf_out_reg;

  logic             dvd_neg, dvs_neg, in_dz, in_ovf, cnt_last;
  logic [W-1:0]     dvd_mag, dvs_mag;
  logic [W-1:0]     step_rem;
  logic             step_q;
`ifdef DIV_FAST_SPECIAL_EN
  logic             fast_take;
`endif

  // Operand decode for the accept cycle: signs, magnitudes, special cases.
  always_comb begin
    dvd_neg = signed_mode && dividend[W-1];
    dvs_neg = signed_mode && divisor[W-1];
    dvd_mag = W'(abs_val(MAX_W'(dividend), dvd_neg));
    dvs_mag = W'(abs_val(MAX_W'(divisor), dvs_neg));
    in_dz   = (divisor == '0);
    in_ovf  = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
    cnt_last = (cnt_reg == CNT_W'(W - 1));
`ifdef DIV_FAST_SPECIAL_EN
    fast_take = in_dz || in_ovf || (dvd_mag < dvs_mag);
`endif
  end

  div_restore_step #(.W(W)) u_step (
    .rem      (rem_reg),
    .q_msb    (quo_reg[W-1]),
    .dmag     (dmag_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_next = fast_take ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: if (cnt_last) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dmag_reg      <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_out_reg    <= 1'b0;
      ovf_out_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= dvd_mag;
            dmag_reg  <= dvs_mag;
            q_neg_reg <= dvd_neg ^ dvs_neg;
            r_neg_reg <= dvd_neg;
            dz_reg    <= in_dz;
            ovf_reg   <= in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_take) begin
              quotient_reg  <= in_dz ? '1 : (in_ovf ? MIN_VAL : '0);
              remainder_reg <= in_ovf ? '0 : dividend;
              dz_out_reg    <= in_dz;
              ovf_out_reg   <= in_ovf;
            end
`endif
          end
        end
        CALC: begin
          rem_reg <= step_rem;
          quo_reg <= {quo_reg[W-2:0], step_q};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        FIX: begin
          // A zero divisor leaves rem = |D|, so re-signing restores the dividend.
          quotient_reg  <= dz_reg  ? '1 :
                           ovf_reg ? MIN_VAL :
                           W'(cond_negate(MAX_W'(quo_reg), q_neg_reg));
          remainder_reg <= ovf_reg ? '0 : W'(cond_negate(MAX_W'(rem_reg), r_neg_reg));
          dz_out_reg    <= dz_reg;
          ovf_out_reg   <= ovf_reg;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dz_out_reg;
  assign overflow    = ovf_out_reg;

endmodule

// File: tb/tb_div_seq_param.sv
// Testbench for div_seq_param (W=8): directed operations with literal
// expectations plus an arithmetic reference model checked every cycle
// the result is valid.
module tb_div_seq_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       signed_mode = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient, remainder;
  logic       div_by_zero, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit prev_valid = 1'b0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  div_seq_param #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, plus the
  // two special cases.
  function automatic exp_t model(input logic sm, input logic [7:0] a,
                                 input logic [7:0] b, input int acc);
    exp_t e;
    int sa, sb, ma, mb;
    sa = sm ? int'($signed(a)) : int'(a);
    sb = sm ? int'($signed(b)) : int'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else if (sm && a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1;
    end else begin
      e.q = 8'(sa / sb);
      e.r = 8'(sa % sb);
    end
    e.acc = acc;
    e.lat = 10;
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 8'h00 || e.ovf || ma < mb) e.lat = 1;
`else
    if (ma < 0 || mb < 0) e.lat = -1;
`endif
    return e;
  endfunction

  // Compare process: every cycle out_valid is high the outputs must match
  // the oldest outstanding expectation.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back(model(signed_mode, dividend, divisor, cyc));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("mon_quotient", int'(quotient), int'(exp_q[0].q));
          chk("mon_remainder", int'(remainder), int'(exp_q[0].r));
          chk("mon_div_by_zero", int'(div_by_zero), int'(exp_q[0].dz));
          chk("mon_overflow", int'(overflow), int'(exp_q[0].ovf));
          if (!prev_valid) chk("mon_latency", cyc - exp_q[0].acc, exp_q[0].lat);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eovf,
                        input bit lit, input int hold);
    int n;
    @(posedge clk); #1;
    signed_mode = sm; dividend = a; divisor = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 8'hA5; divisor = 8'h5A;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
    end else begin
      $display("op sm=%0d 0x%02h/0x%02h -> q=0x%02h r=0x%02h dz=%0d ovf=%0d",
               sm, a, b, quotient, remainder, div_by_zero, overflow);
      if (lit) begin
        chk("lit_quotient", int'(quotient), int'(eq));
        chk("lit_remainder", int'(remainder), int'(er));
        chk("lit_div_by_zero", int'(div_by_zero), int'(edz));
        chk("lit_overflow", int'(overflow), int'(eovf));
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; signed_mode = 1'b0; dividend = 8'h11; divisor = 8'h01;
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drop_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_flags", int'({div_by_zero, overflow}), 0);
    rst_n = 1'b1;

    run_op(1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 0);
    run_op(1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 8'h05,  8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'hFD,  8'h07, 8'h00, 8'hFD, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h80,  8'h02, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'hF9,  8'hFE, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h80,  8'h00, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 0);
    // Result held with out_ready low while new operands are offered.
    run_op(1'b0, 8'hC8,  8'h0A, 8'h14, 8'h00, 1'b0, 1'b0, 1'b1, 5);

    // Reset in the middle of an iteration discards the operation.
    @(posedge clk); #1;
    signed_mode = 1'b0; dividend = 8'h55; divisor = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midcalc_rst_out_valid", int'(out_valid), 0);
    chk("midcalc_rst_in_ready", int'(in_ready), 1);
    run_op(1'b0, 8'd200, 8'd3, 8'h42, 8'h02, 1'b0, 1'b0, 1'b1, 0);

    // Model-only sweep with a sprinkling of zero divisors.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = (k % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_op(1'($urandom_range(0, 1)), ra, rb, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, k % 3);
    end

    repeat (2) @(negedge clk);
    chk("no_pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
